// File: rtl/keypad_scanner.sv
// keypad_scanner: 3x4 matrix keypad column scan, row sync, debounce and key code output
module keypad_scanner #(
   parameter int CLOCK_FREQ             = 50000000,
   parameter int SCAN_PERIOD            = CLOCK_FREQ / 1000,
   parameter int DEBOUNCE_SCANS         = 20,
   parameter int SLOT_COUNTER_WIDTH     = $clog2(SCAN_PERIOD),
   parameter int DEBOUNCE_COUNTER_WIDTH = $clog2(DEBOUNCE_SCANS + 1)
) (
   input  logic       clock,
   input  logic       reset,
   input  logic [3:0] row,
   output logic [2:0] column,
   output logic [3:0] key,
   output logic       keyStrobe
);
   localparam logic [1:0] IDLE          = 2'd0;
   localparam logic [1:0] DEBOUNCE_PRESS = 2'd1;
   localparam logic [1:0] PRESSED       = 2'd2;
   localparam logic [1:0] DEBOUNCE_REL  = 2'd3;
   localparam logic [SLOT_COUNTER_WIDTH-1:0] SLOT_LAST = SLOT_COUNTER_WIDTH'(SCAN_PERIOD - 1);
   localparam logic [DEBOUNCE_COUNTER_WIDTH-1:0] DS_MAX = DEBOUNCE_COUNTER_WIDTH'(DEBOUNCE_SCANS);
   localparam bit DS_ONE = DEBOUNCE_SCANS == 1;
   // snapshot bit i is column i/4, row i%4; nibble i holds that key's code
   localparam logic [47:0] CODES = 48'hF963_A852_E741;

   logic [3:0] row_meta, row_sync;
   logic [SLOT_COUNTER_WIDTH-1:0] slot;
   logic [1:0] col_idx;
   logic [11:0] snap;
   logic scan_done, slot_last;
   logic [3:0] cand, lows;
   logic [1:0] state;
   logic [3:0] pending;
   logic [DEBOUNCE_COUNTER_WIDTH-1:0] count;
   logic reached;

   assign slot_last = slot == SLOT_LAST;
   assign reached = count >= DS_MAX - 1'b1;

   // decode the driven column from the column index
   always_comb column = col_idx == 2'd0 ? 3'b110 : col_idx == 2'd1 ? 3'b101 : 3'b011;

   // two-flop synchroniser for the asynchronous rows
   always_ff @(posedge clock or posedge reset)
      if (reset) {row_meta, row_sync} <= 8'hFF;
      else {row_meta, row_sync} <= {row, row_meta};

   // slot counter, column rotation, snapshot capture and end-of-scan pulse
   always_ff @(posedge clock or posedge reset)
      if (reset) begin
         slot      <= '0;
         col_idx   <= 2'd0;
         snap      <= '1;
         scan_done <= 1'b0;
      end else begin
         slot      <= slot_last ? '0 : slot + 1'b1;
         scan_done <= slot_last && col_idx == 2'd2;
         if (slot_last) begin
            snap[col_idx*4 +: 4] <= row_sync;
            col_idx <= col_idx == 2'd2 ? 2'd0 : col_idx + 2'd1;
         end
      end

   // single-low-bit decode; no key or multiple keys both give code 0
   always_comb begin
      cand = 4'h0;
      lows = 4'd0;
      for (int i = 0; i < 12; i++)
         if (!snap[i]) begin
            lows = lows + 4'd1;
            cand = CODES[i*4 +: 4];
         end
      if (lows != 4'd1) cand = 4'h0;
   end

   // debounce FSM, advancing only once per completed scan
   always_ff @(posedge clock or posedge reset)
      if (reset) begin
         state     <= IDLE;
         pending   <= 4'h0;
         count     <= '0;
         key       <= 4'h0;
         keyStrobe <= 1'b0;
      end else begin
         keyStrobe <= 1'b0;
         if (scan_done)
            case (state)
               IDLE:
                  if (cand != 4'h0) begin
                     pending <= cand;
                     count   <= DEBOUNCE_COUNTER_WIDTH'(1);
                     if (DS_ONE) begin
                        state     <= PRESSED;
                        key       <= cand;
                        keyStrobe <= 1'b1;
                     end else state <= DEBOUNCE_PRESS;
                  end
               DEBOUNCE_PRESS:
                  if (cand == 4'h0) begin
                     state <= IDLE;
                     count <= '0;
                  end else if (cand == pending) begin
                     count <= reached ? DS_MAX : count + 1'b1;
                     if (reached) begin
                        state     <= PRESSED;
                        key       <= pending;
                        keyStrobe <= 1'b1;
                     end
                  end else begin
                     pending <= cand;
                     count   <= DEBOUNCE_COUNTER_WIDTH'(1);
                  end
               PRESSED:
                  if (cand != key) begin
                     count <= DEBOUNCE_COUNTER_WIDTH'(1);
                     if (DS_ONE) begin
                        state <= IDLE;
                        key   <= 4'h0;
                     end else state <= DEBOUNCE_REL;
                  end
               default:
                  if (cand == key) state <= PRESSED;
                  else begin
                     count <= reached ? DS_MAX : count + 1'b1;
                     if (reached) begin
                        state <= IDLE;
                        key   <= 4'h0;
                     end
                  end
            endcase
      end
endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: directed checks of scan rotation, debounce, key map, rollover and reset
module tb_keypad_scanner;
   logic clock = 1'b0;
   logic reset = 1'b1;
   logic [3:0] row;
   logic [2:0] column;
   logic [3:0] key;
   logic keyStrobe;
   logic [11:0] held = '0;
   int tests = 0, fails = 0, strobes = 0;

   keypad_scanner #(.SCAN_PERIOD(4), .DEBOUNCE_SCANS(3)) dut (
      .clock(clock), .reset(reset), .row(row),
      .column(column), .key(key), .keyStrobe(keyStrobe)
   );

   always #5 clock = ~clock;

   // passive keypad: a held key pulls its row low while its column is driven
   always_comb begin
      row = 4'b1111;
      for (int c = 0; c < 3; c++)
         for (int r = 0; r < 4; r++)
            if (held[c*4+r] && !column[c]) row[r] = 1'b0;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick;
      @(negedge clock);
      if (keyStrobe) strobes++;
   endtask

   task automatic wait_key(input string tag, input logic [3:0] exp);
      int n = 0;
      while (key !== exp && n < 51) begin
         tick();
         n++;
      end
      check(tag, key, exp);
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      logic [2:0] colv [3] = '{3'b110, 3'b101, 3'b011};
      logic [3:0] codes [3] = '{4'hA, 4'hE, 4'hF};
      int idx [3] = '{7, 3, 11};
      int s0, bad, n;
      tick();
      tick();
      check("rst_column", column, 3'b110);
      check("rst_key", key, 4'h0);
      check("rst_strobe", keyStrobe, 1'b0);
      reset = 1'b0;
      bad = 0;
      for (int k = 0; k < 24; k++) begin
         check("rotate", column, colv[(k/4)%3]);
         if (key !== 4'h0 || keyStrobe !== 1'b0) bad++;
         tick();
      end
      check("idle_quiet", bad, 0);

      s0 = strobes;
      held[6] = 1'b1;
      wait_key("press_8", 4'h8);
      check("press_8_strobe", strobes - s0, 1);
      bad = 0;
      for (int i = 0; i < 200; i++) begin
         tick();
         if (key !== 4'h8) bad++;
      end
      check("hold_8_stable", bad, 0);
      check("hold_8_one_strobe", strobes - s0, 1);
      held = '0;
      wait_key("release_8", 4'h0);
      check("release_no_strobe", strobes - s0, 1);

      run(40);
      s0 = strobes;
      bad = 0;
      for (int i = 0; i < 96; i++) begin
         held[1] = (i / 12) % 2 == 0;
         tick();
         if (key !== 4'h0) bad++;
      end
      check("bounce_key", bad, 0);
      check("bounce_strobe", strobes - s0, 0);
      held[1] = 1'b1;
      wait_key("steady_4", 4'h4);
      held = '0;
      wait_key("release_4", 4'h0);

      for (int j = 0; j < 3; j++) begin
         held[idx[j]] = 1'b1;
         wait_key("special_press", codes[j]);
         held = '0;
         wait_key("special_release", 4'h0);
      end

      run(40);
      held[0] = 1'b1;
      held[4] = 1'b1;
      bad = 0;
      for (int i = 0; i < 60; i++) begin
         tick();
         if (key !== 4'h0) bad++;
      end
      check("two_keys_blocked", bad, 0);
      held = '0;
      run(40);
      held[0] = 1'b1;
      wait_key("press_1", 4'h1);
      held[4] = 1'b1;
      bad = 0;
      for (int i = 0; i < 24; i++) begin
         tick();
         if (key !== 4'h1) bad++;
      end
      check("rollover_hold_1", bad, 0);
      bad = 0;
      n = 0;
      while (key !== 4'h0 && n < 51) begin
         tick();
         if (key !== 4'h0 && key !== 4'h1) bad++;
         n++;
      end
      check("rollover_release", key, 4'h0);
      check("rollover_no_2", bad, 0);
      held = '0;
      run(40);

      held[10] = 1'b1;
      wait_key("press_9", 4'h9);
      run(3);
      reset = 1'b1;
      #1;
      check("midrst_key", key, 4'h0);
      check("midrst_column", column, 3'b110);
      check("midrst_strobe", keyStrobe, 1'b0);
      tick();
      reset = 1'b0;
      n = 0;
      while (keyStrobe !== 1'b1 && n < 51) begin
         tick();
         n++;
      end
      check("reaccept_strobe", keyStrobe, 1'b1);
      check("reaccept_key", key, 4'h9);
      held = '0;
      wait_key("final_release", 4'h0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/keypad_scanner.md
# keypad_scanner

Matrix-keypad front end for the digital lock: drives the columns of a 3×4 keypad, samples and synchronises the rows, debounces the result and presents a single 4-bit key code. The code is held non-zero for the duration of a press and returns to zero between presses. `key` connects directly to the lock state machine's `key` input, which treats non-zero as pressed and waits for zero before accepting the next digit.

## Interface
- `CLOCK_FREQ`, 50000000: clock frequency in Hz; documentation only.
- `SCAN_PERIOD`, CLOCK_FREQ/1000: clock cycles each column is driven. Must be ≥4.
- `DEBOUNCE_SCANS`, 20: consecutive identical full scans required to accept a press or a release. Must be ≥1.
- `SLOT_COUNTER_WIDTH`, $clog2(SCAN_PERIOD): width of the per-column cycle counter.
- `DEBOUNCE_COUNTER_WIDTH`, $clog2(DEBOUNCE_SCANS+1): width of the stability counter.

Ports:
- `clock`  in  1: single system clock.
- `reset`  in  1: asynchronous, active-high.
- `row`  in  4: raw keypad rows, active-low (external pull-ups), asynchronous to `clock`.
- `column`  out  3: column drive, active-low, exactly one bit low at any time.
- `key`  out  4: debounced key code; 4'h0 = no key.
- `keyStrobe`  out  1: one-cycle pulse when `key` changes from 0 to a non-zero code.

## Operation
- Key map, indexed (row, column), row 0 at the top:
  - Column 0: 1, 4, 7, `*`
  - Column 1: 2, 5, 8, 0
  - Column 2: 3, 6, 9, `#`
  - Codes: digits 1–9 map to 4'h1–4'h9; `0` → 4'hA; `*` → 4'hE; `#` → 4'hF.
- Row synchroniser: two flops, reset to 4'b1111. Everything downstream uses only the synchronised value.
- Scanner:
  - Slot counter runs 0..SCAN_PERIOD-1, then wraps.
  - `column` rotates 3'b110 → 3'b101 → 3'b011 → 3'b110, advancing when the slot counter wraps.
  - The synchronised rows are captured into a 12-bit snapshot on slot count SCAN_PERIOD-1 of each column.
  - After the capture of column 2, `scanDone` pulses for one cycle.
- Candidate, evaluated on `scanDone`:
  - Exactly one snapshot bit low: candidate = that key's code.
  - Zero bits low, or two or more bits low (ghosting/rollover): candidate = 4'h0.
- Debounce FSM. It acts only on `scanDone` cycles and holds its state otherwise.
  - IDLE (`key`=0):
    - candidate≠0 → DEBOUNCE_PRESS, with pending=candidate and count=1.
    - If DEBOUNCE_SCANS==1, go directly to PRESSED.
  - DEBOUNCE_PRESS:
    - candidate==pending: count+1. When the count reaches DEBOUNCE_SCANS → PRESSED, `key`=pending, `keyStrobe`=1 for that cycle.
    - candidate==0 → IDLE.
    - Other non-zero candidate: pending=candidate, count=1.
  - PRESSED:
    - candidate==`key`: stay.
    - Otherwise → DEBOUNCE_RELEASE, count=1.
  - DEBOUNCE_RELEASE:
    - candidate==`key` → PRESSED.
    - Otherwise count+1. When the count reaches DEBOUNCE_SCANS → IDLE, `key`=0.
- A second key pressed while the first is held does not change `key`. A new code is presented only after `key` has returned to 0, so the lock always sees a zero gap between digits.
- The count saturates at DEBOUNCE_SCANS and never wraps.

## Timing
- Reset values:
  - `column` = 3'b110, `key` = 4'h0, `keyStrobe` = 0.
  - FSM in IDLE; slot, column and debounce counters = 0; synchroniser = 4'b1111.
- One full scan takes 3×SCAN_PERIOD cycles.
- Row-to-snapshot latency is 2 cycles. Because SCAN_PERIOD ≥ 4, the capture always reflects the currently driven column.
- `key` and `keyStrobe` update in the cycle after `scanDone`; `keyStrobe` is high for exactly that one cycle.
- Press latency, from a stable contact to `key` non-zero: at most (DEBOUNCE_SCANS+1)×3×SCAN_PERIOD+3 cycles. Release latency has the same bound.
- Reset asserted mid-press or mid-debounce immediately returns all outputs to their reset values. Scanning restarts from column 0.

## Test plan
Use `SCAN_PERIOD`=4 and `DEBOUNCE_SCANS`=3.
- **Reset and scan rotation:** reset, then run 24 cycles with no key. Expect `column` to sequence 110, 101, 011 every 4 cycles, `key`=0 and `keyStrobe`=0 throughout.
- **Press and hold:** hold key "8" (row 2 low while column 1 is low) for 20 scans. Expect `key`=4'h8 within 48 cycles, exactly one `keyStrobe` pulse, and `key` stable for the rest of the hold. After release, expect `key`=0 within 48 cycles.
- **Bounce rejection:** toggle key "4" every 12 cycles (one scan) for 8 scans. Expect `key` to stay 0 and no `keyStrobe`. Then hold it steady and expect `key`=4'h4.
- **Special keys:** press "0", "*" and "#" in turn, releasing between presses. Expect `key` values 4'hA, 4'hE and 4'hF, with 0 between each.
- **Multi-key and rollover:**
  - With no key held, press "1" and "2" together. Expect `key` to stay 0.
  - Hold "1" until `key`=4'h1, then add "2". Expect `key` to stay 4'h1 until three scans of the two-key candidate (0) accumulate, then 0.
- **Reset mid-press:** while `key`=4'h9, assert `reset` for one cycle. Expect `key`=0 and `column`=3'b110 immediately. If "9" is still held, expect re-acceptance and a fresh `keyStrobe` after 3 stable scans.
